// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: widths, opcodes, instruction
// field positions, immediate kinds and the decode/ID-EX record types.
package risc_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;
  localparam int OP_W     = 4;

  localparam int OP_LSB = 12;
  localparam int RA_LSB = 9;
  localparam int RB_LSB = 6;
  localparam int RC_LSB = 3;
  localparam int IMM6_W = 6;
  localparam int IMM9_W = 9;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADI  = 4'b0001;
  localparam logic [OP_W-1:0] OP_NAND = 4'b0010;
  localparam logic [OP_W-1:0] OP_LHI  = 4'b0011;
  localparam logic [OP_W-1:0] OP_LW   = 4'b0100;
  localparam logic [OP_W-1:0] OP_SW   = 4'b0101;
  localparam logic [OP_W-1:0] OP_JAL  = 4'b1000;
  localparam logic [OP_W-1:0] OP_JLR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'b1100;

  typedef enum logic [1:0] {
    IMM_NONE  = 2'd0,
    IMM_SEXT6 = 2'd1,
    IMM_SEXT9 = 2'd2,
    IMM_HI9   = 2'd3
  } imm_kind_e;

  typedef struct packed {
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic [REG_AW-1:0] rd;
    logic              use_ra;
    logic              use_rb;
    imm_kind_e         imm_kind;
  } dec_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc_1;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
  } idex_t;

  // imm6 is the low six bits of the imm9 field, so one field feeds every kind.
  function automatic logic [DATA_W-1:0] gen_imm(input logic [IMM9_W-1:0] imm9,
                                                input imm_kind_e kind);
    logic [DATA_W-1:0] imm;
    case (kind)
      IMM_SEXT6: imm = {{(DATA_W-IMM6_W){imm9[IMM6_W-1]}}, imm9[IMM6_W-1:0]};
      IMM_SEXT9: imm = {{(DATA_W-IMM9_W){imm9[IMM9_W-1]}}, imm9};
      IMM_HI9:   imm = {imm9, {(DATA_W-IMM9_W){1'b0}}};
      IMM_NONE:  imm = {DATA_W{1'b0}};
      default:   imm = {DATA_W{1'b0}};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side, write-back and ID/EX signals of the decode stage; the stage
// itself uses the slave modport, the surrounding pipeline the master modport.
interface instr_decode_stage_if;
  import risc_pkg::*;

  logic [DATA_W-1:0] IR;
  logic [DATA_W-1:0] PC_1;
  logic              if_valid;
  logic              flush;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              stall_out;
  logic              id_valid;
  logic [OP_W-1:0]   id_opcode;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_ra_data;
  logic [DATA_W-1:0] id_rb_data;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc_1;
  logic              id_reg_wr;
  logic              id_mem_rd;
  logic              id_mem_wr;

  modport master (
    output IR, PC_1, if_valid, flush, wb_en, wb_addr, wb_data,
    input  stall_out, id_valid, id_opcode, id_rd, id_ra_data, id_rb_data,
           id_imm, id_pc_1, id_reg_wr, id_mem_rd, id_mem_wr
  );

  modport slave (
    input  IR, PC_1, if_valid, flush, wb_en, wb_addr, wb_data,
    output stall_out, id_valid, id_opcode, id_rd, id_ra_data, id_rb_data,
           id_imm, id_pc_1, id_reg_wr, id_mem_rd, id_mem_wr
  );

endinterface

// File: rtl/reg_file_8x16.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port.
// Defining ID_WB_BYPASS_EN makes a same-cycle write visible on the read ports.
module reg_file_8x16
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_en_eff;

  // A write-back arriving during reset must neither land nor bypass.
  assign wr_en_eff = wr_en & ~reset;

  // Next register contents: the addressed entry takes the write data.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_eff) begin
      regs_d[wr_addr] = wr_data;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef ID_WB_BYPASS_EN
  // Read ports with write-before-read forwarding.
  always_comb begin
    if (wr_en_eff && (wr_addr == ra_addr)) begin
      ra_data = wr_data;
    end else begin
      ra_data = regs_q[ra_addr];
    end
    if (wr_en_eff && (wr_addr == rb_addr)) begin
      rb_data = wr_data;
    end else begin
      rb_data = regs_q[rb_addr];
    end
  end
`else
  // Read ports return the stored value; a write shows up one cycle later.
  always_comb begin
    ra_data = regs_q[ra_addr];
    rb_data = regs_q[rb_addr];
  end
`endif

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage of the 16-bit RISC core: IF/ID register, field decode, register
// read, load-use stall, flush and registered ID/EX bundle. Option: ID_WB_BYPASS_EN.
module instr_decode_stage
  import risc_pkg::*;
(
  input  logic                CLK,
  input  logic                reset,
  instr_decode_stage_if.slave bus
);

  logic              if_id_valid_q, if_id_valid_d;
  logic [DATA_W-1:0] if_id_ir_q, if_id_ir_d;
  logic [DATA_W-1:0] if_id_pc_1_q, if_id_pc_1_d;
  idex_t             idex_q, idex_d;

  logic [OP_W-1:0]   opcode;
  logic [REG_AW-1:0] ra_addr, rb_addr, rc_addr;
  logic [IMM9_W-1:0] imm9_field;
  logic [DATA_W-1:0] ra_data, rb_data;
  dec_t              dec;
  logic              hazard;
  logic              stall;

  assign opcode     = if_id_ir_q[OP_LSB +: OP_W];
  assign ra_addr    = if_id_ir_q[RA_LSB +: REG_AW];
  assign rb_addr    = if_id_ir_q[RB_LSB +: REG_AW];
  assign rc_addr    = if_id_ir_q[RC_LSB +: REG_AW];
  assign imm9_field = if_id_ir_q[IMM9_W-1:0];

  reg_file_8x16 u_reg_file (
    .clk     (CLK),
    .reset   (reset),
    .wr_en   (bus.wb_en),
    .wr_addr (bus.wb_addr),
    .wr_data (bus.wb_data),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .ra_data (ra_data),
    .rb_data (rb_data)
  );

  // Per-opcode destination, source usage, memory controls and immediate kind.
  always_comb begin
    dec = '{reg_wr: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0, rd: {REG_AW{1'b0}},
            use_ra: 1'b0, use_rb: 1'b0, imm_kind: IMM_NONE};
    case (opcode)
      OP_ADD, OP_NAND: begin
        dec.reg_wr = 1'b1; dec.rd = rc_addr;
        dec.use_ra = 1'b1; dec.use_rb = 1'b1;
      end
      OP_ADI: begin
        dec.reg_wr = 1'b1; dec.rd = rb_addr;
        dec.use_ra = 1'b1; dec.imm_kind = IMM_SEXT6;
      end
      OP_LHI: begin
        dec.reg_wr = 1'b1; dec.rd = ra_addr; dec.imm_kind = IMM_HI9;
      end
      OP_LW: begin
        dec.reg_wr = 1'b1; dec.rd = ra_addr; dec.mem_rd = 1'b1;
        dec.use_rb = 1'b1; dec.imm_kind = IMM_SEXT6;
      end
      OP_SW: begin
        dec.mem_wr = 1'b1; dec.use_ra = 1'b1; dec.use_rb = 1'b1;
        dec.imm_kind = IMM_SEXT6;
      end
      OP_BEQ: begin
        dec.use_ra = 1'b1; dec.use_rb = 1'b1; dec.imm_kind = IMM_SEXT6;
      end
      OP_JAL: begin
        dec.reg_wr = 1'b1; dec.rd = ra_addr; dec.imm_kind = IMM_SEXT9;
      end
      OP_JLR: begin
        dec.reg_wr = 1'b1; dec.rd = ra_addr; dec.use_rb = 1'b1;
      end
      default: begin
        dec.reg_wr = 1'b0;
      end
    endcase
  end

  // Load in ID/EX whose destination is a source actually read by IF/ID.
  always_comb begin
    hazard = 1'b0;
    if (idex_q.valid && idex_q.mem_rd && if_id_valid_q) begin
      hazard = (dec.use_ra && (ra_addr == idex_q.rd)) ||
               (dec.use_rb && (rb_addr == idex_q.rd));
    end else begin
      hazard = 1'b0;
    end
  end

  assign stall = ~reset & ~bus.flush & hazard;

  // Next IF/ID and ID/EX contents; flush beats stall, both insert a bubble.
  always_comb begin
    if_id_valid_d = if_id_valid_q;
    if_id_ir_d    = if_id_ir_q;
    if_id_pc_1_d  = if_id_pc_1_q;
    idex_d        = '0;
    if (bus.flush) begin
      if_id_valid_d = 1'b0;
    end else if (hazard) begin
      if_id_valid_d = if_id_valid_q;
    end else begin
      if_id_valid_d = bus.if_valid;
      if_id_ir_d    = bus.IR;
      if_id_pc_1_d  = bus.PC_1;
    end

    if (!bus.flush && !hazard && if_id_valid_q) begin
      idex_d.valid   = 1'b1;
      idex_d.opcode  = opcode;
      idex_d.rd      = dec.rd;
      idex_d.ra_data = ra_data;
      idex_d.rb_data = rb_data;
      idex_d.imm     = gen_imm(imm9_field, dec.imm_kind);
      idex_d.pc_1    = if_id_pc_1_q;
      idex_d.reg_wr  = dec.reg_wr;
      idex_d.mem_rd  = dec.mem_rd;
      idex_d.mem_wr  = dec.mem_wr;
    end else begin
      idex_d = '0;
    end
  end

  // IF/ID and ID/EX pipeline registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      if_id_valid_q <= 1'b0;
      if_id_ir_q    <= {DATA_W{1'b0}};
      if_id_pc_1_q  <= {DATA_W{1'b0}};
      idex_q        <= '0;
    end else begin
      if_id_valid_q <= if_id_valid_d;
      if_id_ir_q    <= if_id_ir_d;
      if_id_pc_1_q  <= if_id_pc_1_d;
      idex_q        <= idex_d;
    end
  end

  assign bus.stall_out  = stall;
  assign bus.id_valid   = idex_q.valid;
  assign bus.id_opcode  = idex_q.opcode;
  assign bus.id_rd      = idex_q.rd;
  assign bus.id_ra_data = idex_q.ra_data;
  assign bus.id_rb_data = idex_q.rb_data;
  assign bus.id_imm     = idex_q.imm;
  assign bus.id_pc_1    = idex_q.pc_1;
  assign bus.id_reg_wr  = idex_q.reg_wr;
  assign bus.id_mem_rd  = idex_q.mem_rd;
  assign bus.id_mem_wr  = idex_q.mem_wr;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: expected ID/EX bundles are queued
// at issue and compared whenever id_valid is seen.
module tb_instr_decode_stage;
  import risc_pkg::*;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [15:0] rm [8];

  always #5 clk = ~clk;

  instr_decode_stage_if bus();

  instr_decode_stage dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] r_type(input logic [3:0] op, input logic [2:0] a,
                                         input logic [2:0] b, input logic [2:0] c);
    return {op, a, b, c, 3'b000};
  endfunction

  function automatic logic [15:0] i_type(input logic [3:0] op, input logic [2:0] a,
                                         input logic [2:0] b, input logic [5:0] i6);
    return {op, a, b, i6};
  endfunction

  function automatic logic [15:0] j_type(input logic [3:0] op, input logic [2:0] a,
                                         input logic [8:0] i9);
    return {op, a, i9};
  endfunction

  function automatic exp_t exp_of(input logic [15:0] ir, input logic [15:0] pc);
    exp_t e;
    logic [15:0] s6, s9, hi;
    e = '0;
    e.opcode = ir[15:12];
    e.ra = rm[ir[11:9]];
    e.rb = rm[ir[8:6]];
    e.pc = pc;
    s6 = {{10{ir[5]}}, ir[5:0]};
    s9 = {{7{ir[8]}}, ir[8:0]};
    hi = {ir[8:0], 7'b0000000};
    case (ir[15:12])
      4'b0000, 4'b0010: begin e.rd = ir[5:3]; e.reg_wr = 1'b1; end
      4'b0001: begin e.rd = ir[8:6]; e.reg_wr = 1'b1; e.imm = s6; end
      4'b0011: begin e.rd = ir[11:9]; e.reg_wr = 1'b1; e.imm = hi; end
      4'b0100: begin e.rd = ir[11:9]; e.reg_wr = 1'b1; e.mem_rd = 1'b1; e.imm = s6; end
      4'b0101: begin e.mem_wr = 1'b1; e.imm = s6; end
      4'b1100: begin e.imm = s6; end
      4'b1000: begin e.rd = ir[11:9]; e.reg_wr = 1'b1; e.imm = s9; end
      4'b1001: begin e.rd = ir[11:9]; e.reg_wr = 1'b1; end
      default: begin e.reg_wr = 1'b0; end
    endcase
    return e;
  endfunction

  task automatic observe();
    exp_t e;
    if (bus.id_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk_eq("sb_unexpected_valid", {31'd0, bus.id_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk_eq("id_opcode", {28'd0, bus.id_opcode}, {28'd0, e.opcode});
        chk_eq("id_rd", {29'd0, bus.id_rd}, {29'd0, e.rd});
        chk_eq("id_ra_data", {16'd0, bus.id_ra_data}, {16'd0, e.ra});
        chk_eq("id_rb_data", {16'd0, bus.id_rb_data}, {16'd0, e.rb});
        chk_eq("id_imm", {16'd0, bus.id_imm}, {16'd0, e.imm});
        chk_eq("id_pc_1", {16'd0, bus.id_pc_1}, {16'd0, e.pc});
        chk_eq("id_reg_wr", {31'd0, bus.id_reg_wr}, {31'd0, e.reg_wr});
        chk_eq("id_mem_rd", {31'd0, bus.id_mem_rd}, {31'd0, e.mem_rd});
        chk_eq("id_mem_wr", {31'd0, bus.id_mem_wr}, {31'd0, e.mem_wr});
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic drive(input logic [15:0] ir, input logic [15:0] pc, input logic v);
    bus.IR = ir;
    bus.PC_1 = pc;
    bus.if_valid = v;
  endtask

  task automatic issue(input logic [15:0] ir, input logic [15:0] pc);
    drive(ir, pc, 1'b1);
    sb.push_back(exp_of(ir, pc));
    cyc();
  endtask

  task automatic idle(input int n);
    drive(16'h0000, 16'h0000, 1'b0);
    repeat (n) cyc();
  endtask

  task automatic wb(input logic [2:0] addr, input logic [15:0] data);
    bus.wb_en = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    cyc();
    bus.wb_en = 1'b0;
    rm[addr] = data;
  endtask

  task automatic chk_outputs_zero();
    chk_eq("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk_eq("rst_id_opcode", {28'd0, bus.id_opcode}, 32'd0);
    chk_eq("rst_id_rd", {29'd0, bus.id_rd}, 32'd0);
    chk_eq("rst_id_ra_data", {16'd0, bus.id_ra_data}, 32'd0);
    chk_eq("rst_id_rb_data", {16'd0, bus.id_rb_data}, 32'd0);
    chk_eq("rst_id_imm", {16'd0, bus.id_imm}, 32'd0);
    chk_eq("rst_id_pc_1", {16'd0, bus.id_pc_1}, 32'd0);
    chk_eq("rst_id_ctrl", {29'd0, bus.id_reg_wr, bus.id_mem_rd, bus.id_mem_wr}, 32'd0);
    chk_eq("rst_stall_out", {31'd0, bus.stall_out}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 8; i++) rm[i] = 16'h0000;
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.wb_en = 1'b1;
    bus.wb_addr = 3'd3;
    bus.wb_data = 16'h1234;
    drive(r_type(OP_ADD, 3'd3, 3'd3, 3'd1), 16'h0010, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_outputs_zero();
    end
    reset = 1'b0;
    bus.wb_en = 1'b0;
    idle(1);

    // R3 read after reset (write during reset ignored)
    issue(r_type(OP_ADD, 3'd3, 3'd3, 3'd1), 16'h0011);
    idle(2);

    wb(3'd1, 16'h0005);
    wb(3'd2, 16'h0202);
    wb(3'd3, 16'h0033);
    wb(3'd4, 16'h4444);
    idle(1);

    // ADI decode
    issue(i_type(OP_ADI, 3'd1, 3'd2, 6'h3E), 16'h0021);
    idle(2);

    // back-to-back mix, then an invalid slot carrying a load
    issue(r_type(OP_NAND, 3'd1, 3'd3, 3'd5), 16'h0030);
    issue(i_type(OP_SW, 3'd1, 3'd3, 6'h05), 16'h0031);
    issue(i_type(OP_BEQ, 3'd3, 3'd1, 6'h20), 16'h0032);
    issue(r_type(OP_JLR, 3'd6, 3'd1, 3'd0), 16'h0033);
    issue(16'hF5A5, 16'h0034);
    drive(i_type(OP_LW, 3'd4, 3'd1, 6'h00), 16'h0035, 1'b0);
    cyc();
    issue(r_type(OP_ADD, 3'd4, 3'd1, 3'd5), 16'h0036);
    idle(2);

    // LHI / JAL immediates
    issue(j_type(OP_LHI, 3'd7, 9'h1FF), 16'h0038);
    issue(j_type(OP_JAL, 3'd6, 9'h100), 16'h0039);
    idle(2);

    // load-use stall
    issue(i_type(OP_LW, 3'd4, 3'd1, 6'h02), 16'h0040);
    drive(r_type(OP_ADD, 3'd4, 3'd1, 3'd5), 16'h0041, 1'b1);
    sb.push_back(exp_of(r_type(OP_ADD, 3'd4, 3'd1, 3'd5), 16'h0041));
    cyc();
    drive(16'h0000, 16'h0000, 1'b0);
    #1;
    chk_eq("lu_stall_on", {31'd0, bus.stall_out}, 32'd1);
    cyc();
    chk_eq("lu_bubble", {31'd0, bus.id_valid}, 32'd0);
    chk_eq("lu_stall_off", {31'd0, bus.stall_out}, 32'd0);
    cyc();
    chk_eq("lu_add_out", {31'd0, bus.id_valid}, 32'd1);
    idle(2);

    // flush during a pending load-use stall
    issue(i_type(OP_LW, 3'd4, 3'd1, 6'h00), 16'h0050);
    drive(r_type(OP_ADD, 3'd4, 3'd1, 3'd5), 16'h0051, 1'b1);
    cyc();
    drive(16'h0000, 16'h0000, 1'b0);
    bus.flush = 1'b1;
    #1;
    chk_eq("fl_stall_masked", {31'd0, bus.stall_out}, 32'd0);
    cyc();
    bus.flush = 1'b0;
    chk_eq("fl_bubble", {31'd0, bus.id_valid}, 32'd0);
    cyc();
    chk_eq("fl_ifid_discarded", {31'd0, bus.id_valid}, 32'd0);
    idle(1);

    // write-back in the same cycle as the R2 read
    drive(r_type(OP_ADD, 3'd1, 3'd2, 3'd6), 16'h0060, 1'b1);
    e = exp_of(r_type(OP_ADD, 3'd1, 3'd2, 3'd6), 16'h0060);
    cyc();
    drive(16'h0000, 16'h0000, 1'b0);
    bus.wb_en = 1'b1;
    bus.wb_addr = 3'd2;
    bus.wb_data = 16'hBEEF;
`ifdef ID_WB_BYPASS_EN
    e.rb = 16'hBEEF;
`endif
    sb.push_back(e);
    cyc();
    bus.wb_en = 1'b0;
    rm[2] = 16'hBEEF;
    issue(r_type(OP_ADD, 3'd2, 3'd2, 3'd7), 16'h0062);
    idle(2);

    // reset in the middle of a pending stall
    issue(i_type(OP_LW, 3'd4, 3'd1, 6'h00), 16'h0070);
    drive(r_type(OP_ADD, 3'd4, 3'd1, 3'd5), 16'h0071, 1'b1);
    cyc();
    reset = 1'b1;
    #1;
    chk_eq("mr_stall_masked", {31'd0, bus.stall_out}, 32'd0);
    @(posedge clk);
    #1;
    chk_eq("mr_id_valid", {31'd0, bus.id_valid}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) rm[i] = 16'h0000;
    idle(2);
    issue(r_type(OP_ADD, 3'd1, 3'd4, 3'd0), 16'h0080);
    idle(2);

    chk_eq("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
